// File: rtl/memory_access_pipeline_unit.sv
// memory_access_pipeline_unit
// Memory-access stage register. Latches instruction, effective address and
// store data from execute, issues LDR/STR/LDRB/STRB requests to data memory
// over a req/ready handshake, stalls execute and emits NOP bubbles while a
// request is outstanding, then forwards the instruction with formatted load
// data to the memory-wait stage.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   instr_in/addr_in/str_data_in  operands from execute
//   cond_pass_in                condition passed; 0 turns ld/st into a no-op
//   mem_ready/mem_rdata         memory completion and read word
//   mem_req/mem_we/mem_addr/mem_wdata/mem_byte_en  memory request
//   stall_out                   hold the execute stage
//   instr_output                instruction to memory-wait stage (NOP bubble)
//   load_data_out/load_valid_out  formatted load result
//   stall_cycles                ACCESS-cycle counter
//
// Optional feature: define MEM_STALL_COUNT_EN to build the saturating
// ACCESS-cycle counter; otherwise stall_cycles is tied to zero.
module memory_access_pipeline_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] str_data_in,
  input  logic        cond_pass_in,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  output logic        stall_out,
  output logic [31:0] instr_output,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic [31:0] stall_cycles
);

  localparam logic [31:0] NOP = 32'hE320F000;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic        mem_req_q, mem_req_d;
  logic        load_valid_q, load_valid_d;

  logic        in_is_mem;
  logic        is_load;
  logic        is_byte;
  logic [1:0]  lane;
  logic [31:0] rdata_fmt;

  assign in_is_mem = (instr_in[27:26] == 2'b01) && cond_pass_in;
  assign is_load   = instr_q[20];
  assign is_byte   = instr_q[22];
  assign lane      = addr_q[1:0];

  // Byte loads zero-extend the addressed lane; word loads rotate right by
  // the byte offset (ARM unaligned word load behaviour).
  always_comb begin
    rdata_fmt = '0;
    if (is_byte) begin
      unique case (lane)
        2'd0: rdata_fmt = {24'h0, mem_rdata[7:0]};
        2'd1: rdata_fmt = {24'h0, mem_rdata[15:8]};
        2'd2: rdata_fmt = {24'h0, mem_rdata[23:16]};
        2'd3: rdata_fmt = {24'h0, mem_rdata[31:24]};
        default: rdata_fmt = '0;
      endcase
    end else begin
      unique case (lane)
        2'd0: rdata_fmt = mem_rdata;
        2'd1: rdata_fmt = {mem_rdata[7:0],  mem_rdata[31:8]};
        2'd2: rdata_fmt = {mem_rdata[15:0], mem_rdata[31:16]};
        2'd3: rdata_fmt = {mem_rdata[23:0], mem_rdata[31:24]};
        default: rdata_fmt = mem_rdata;
      endcase
    end
  end

  // Moore outputs (mem_req, instr_output, load_valid) are computed one edge
  // early from the next state so they leave the flops already settled.
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    load_data_d  = load_data_q;
    instr_out_d  = instr_out_q;
    mem_req_d    = mem_req_q;
    load_valid_d = load_valid_q;
    unique case (state_q)
      IDLE, DONE: begin
        instr_d      = instr_in;
        addr_d       = addr_in;
        wdata_d      = str_data_in;
        load_valid_d = 1'b0;
        if (in_is_mem) begin
          state_d     = ACCESS;
          mem_req_d   = 1'b1;
          instr_out_d = NOP;
        end else begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          instr_out_d = instr_in;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d      = DONE;
          mem_req_d    = 1'b0;
          instr_out_d  = instr_q;
          load_valid_d = is_load;
          if (is_load) begin
            load_data_d = rdata_fmt;
          end
        end
      end
      default: begin
        state_d      = IDLE;
        mem_req_d    = 1'b0;
        instr_out_d  = NOP;
        load_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      instr_q      <= NOP;
      addr_q       <= '0;
      wdata_q      <= '0;
      load_data_q  <= '0;
      instr_out_q  <= NOP;
      mem_req_q    <= 1'b0;
      load_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      load_data_q  <= load_data_d;
      instr_out_q  <= instr_out_d;
      mem_req_q    <= mem_req_d;
      load_valid_q <= load_valid_d;
    end
  end

  assign mem_req        = mem_req_q;
  assign stall_out      = mem_req_q;
  assign instr_output   = instr_out_q;
  assign load_data_out  = load_data_q;
  assign load_valid_out = load_valid_q;
  assign mem_we         = ~instr_q[20];
  assign mem_addr       = {addr_q[31:2], 2'b00};
  assign mem_byte_en    = is_byte ? (4'b0001 << lane) : 4'b1111;
  assign mem_wdata      = is_byte ? {4{wdata_q[7:0]}} : wdata_q;

`ifdef MEM_STALL_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == ACCESS && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_memory_access_pipeline_unit.sv
module tb_memory_access_pipeline_unit;

  localparam logic [31:0] NOP = 32'hE320F000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_in, addr_in, str_data_in;
  logic        cond_pass_in;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we, stall_out, load_valid_out;
  logic [31:0] mem_addr, mem_wdata, instr_output, load_data_out, stall_cycles;
  logic [3:0]  mem_byte_en;

  memory_access_pipeline_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_in       (instr_in),
    .addr_in        (addr_in),
    .str_data_in    (str_data_in),
    .cond_pass_in   (cond_pass_in),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_byte_en    (mem_byte_en),
    .stall_out      (stall_out),
    .instr_output   (instr_output),
    .load_data_out  (load_data_out),
    .load_valid_out (load_valid_out),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic        cond;
    int unsigned waitc;
  } stim_t;

  typedef struct {
    logic [31:0] instr;
    logic        bubble;
    logic        lv;
    logic [31:0] ld;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_be;
    logic        chk_wd;
    int unsigned waitc;
    logic [31:0] rdata;
  } req_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  req_t  req_q[$];

  int          checks = 0;
  int          failures = 0;
  int unsigned exp_stall = 0;
  int unsigned resp_cnt = 0;
  logic        run_mon = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference load formatting from the architectural rules.
  function automatic logic [31:0] fmt_load(input logic [31:0] rd, input logic [1:0] off,
                                           input logic byte_op);
    logic [63:0] dbl;
    int unsigned sh;
    sh  = 8 * int'(off);
    dbl = {rd, rd};
    if (byte_op) return (rd >> sh) & 32'h0000_00FF;
    return dbl[31:0] & 32'h0 | 32'(dbl >> sh);
  endfunction

  task automatic push_stim(input logic [31:0] instr, input logic [31:0] addr,
                           input logic [31:0] data, input logic cond,
                           input int unsigned w, input logic [31:0] rdata);
    stim_t s;
    s.instr = instr; s.addr = addr; s.data = data;
    s.cond = cond; s.waitc = w; s.rdata = rdata;
    stim_q.push_back(s);
  endtask

  // Driver: whenever the stage is not stalled, the value presented now is
  // consumed at the next rising edge, so expectations are pushed here.
  always @(negedge clk) begin : drv
    stim_t s;
    exp_t  e;
    req_t  r;
    logic  is_mem;
    if (rst_n === 1'b1 && stall_out === 1'b0) begin
      if (stim_q.size() > 0) begin
        s = stim_q.pop_front();
      end else begin
        s.instr = NOP; s.addr = '0; s.data = '0;
        s.cond = 1'b1; s.waitc = 0; s.rdata = '0;
      end
      instr_in     = s.instr;
      addr_in      = s.addr;
      str_data_in  = s.data;
      cond_pass_in = s.cond;
      is_mem = (s.instr[27:26] == 2'b01) && s.cond;
      if (is_mem) begin
        for (int unsigned i = 0; i <= s.waitc; i++) begin
          e.instr = NOP; e.bubble = 1'b1; e.lv = 1'b0; e.ld = '0;
          exp_q.push_back(e);
        end
        e.instr = s.instr; e.bubble = 1'b0; e.lv = s.instr[20];
        e.ld = fmt_load(s.rdata, s.addr[1:0], s.instr[22]);
        exp_q.push_back(e);
        r.we     = ~s.instr[20];
        r.addr   = {s.addr[31:2], 2'b00};
        r.be     = s.instr[22] ? (4'b0001 << s.addr[1:0]) : 4'b1111;
        r.wdata  = s.instr[22] ? {4{s.data[7:0]}} : s.data;
        r.chk_be = ~(s.instr[20] & s.instr[22]);
        r.chk_wd = ~s.instr[20];
        r.waitc  = s.waitc;
        r.rdata  = s.rdata;
        req_q.push_back(r);
        exp_stall += s.waitc + 1;
      end else begin
        e.instr = s.instr; e.bubble = 1'b0; e.lv = 1'b0; e.ld = '0;
        exp_q.push_back(e);
      end
    end
  end

  // Memory responder: checks the request on its first cycle, answers after
  // the chosen number of wait cycles, and toggles mem_ready randomly when idle.
  always @(negedge clk) begin : responder
    if (rst_n !== 1'b1) begin
      resp_cnt  = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
    end else if (mem_req === 1'b1) begin
      if (req_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_req actual=mem_req=1 required=mem_req=0 @%0t", $time);
        mem_ready = 1'b0;
      end else begin
        if (resp_cnt == 0) begin
          check32("req_we", {31'h0, mem_we}, {31'h0, req_q[0].we});
          check32("req_addr", mem_addr, req_q[0].addr);
          if (req_q[0].chk_be) check32("req_byte_en", {28'h0, mem_byte_en}, {28'h0, req_q[0].be});
          if (req_q[0].chk_wd) check32("req_wdata", mem_wdata, req_q[0].wdata);
        end
        if (resp_cnt == req_q[0].waitc) begin
          mem_ready = 1'b1;
          mem_rdata = req_q[0].rdata;
          void'(req_q.pop_front());
          resp_cnt = 0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          resp_cnt++;
        end
      end
    end else begin
      mem_ready = 1'(($urandom_range(0, 1)));
      mem_rdata = $urandom;
    end
  end

  // Monitor: one expected record per cycle after each rising edge.
  always begin : monitor
    exp_t e;
    @(posedge clk);
    #2;
    if (rst_n === 1'b1 && run_mon) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL exp_underflow actual=instr_output=%h required=queued_expectation @%0t",
                 instr_output, $time);
      end else begin
        e = exp_q.pop_front();
        check32("instr_output", instr_output, e.instr);
        check32("stall_out", {31'h0, stall_out}, {31'h0, e.bubble});
        check32("mem_req", {31'h0, mem_req}, {31'h0, e.bubble});
        check32("load_valid_out", {31'h0, load_valid_out}, {31'h0, e.lv});
        if (e.lv) check32("load_data_out", load_data_out, e.ld);
      end
    end
  end

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    do begin
      @(posedge clk);
      #3;
      n++;
    end while ((stim_q.size() != 0 || exp_q.size() != 0 || req_q.size() != 0) && n < 3000);
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=pending required=drained @%0t", name, $time);
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef MEM_STALL_COUNT_EN
    return exp_stall;
`else
    return 32'h0;
`endif
  endfunction

  task automatic push_random(input int unsigned n);
    logic [31:0] instr;
    for (int unsigned i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) instr = {4'hE, 2'b00, 26'($urandom)};
      else                           instr = {4'hE, 2'b01, 26'($urandom)};
      push_stim(instr, $urandom, $urandom, ($urandom_range(0, 9) != 0),
                $urandom_range(0, 3), $urandom);
    end
  endtask

  initial begin
    int unsigned n;
    rst_n        = 1'b0;
    instr_in     = NOP;
    addr_in      = '0;
    str_data_in  = '0;
    cond_pass_in = 1'b1;
    mem_ready    = 1'b0;
    mem_rdata    = '0;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_instr_output", instr_output, NOP);
    check32("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check32("rst_stall_out", {31'h0, stall_out}, 32'h0);
    check32("rst_load_valid", {31'h0, load_valid_out}, 32'h0);
    check32("rst_load_data", load_data_out, 32'h0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_stall_cycles", stall_cycles, 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    begin
      exp_t e;
      e.instr = NOP; e.bubble = 1'b0; e.lv = 1'b0; e.ld = '0;
      exp_q.push_back(e);
    end
    run_mon = 1'b1;

    // STRB, 3 ACCESS cycles, counter starts from zero
    push_stim(32'hE5C10000, 32'h0000_0202, 32'h1234_5678, 1'b1, 2, 32'h0);
    drain("strb");
    check32("stall_cycles_strb", stall_cycles, exp_count());

    // Directed loads, condition-failed store, back-to-back loads, ALU ops
    push_stim(32'hE5910000, 32'h0000_0100, 32'h0, 1'b1, 0, 32'hDEAD_BEEF);
    push_stim(32'hE0810002, 32'h0, 32'h0, 1'b1, 0, 32'h0);
    push_stim(32'hE5D10000, 32'h0000_0103, 32'h0, 1'b1, 0, 32'hAABB_CCDD);
    push_stim(32'hE5910000, 32'h0000_0101, 32'h0, 1'b1, 0, 32'hAABB_CCDD);
    push_stim(32'hE5810000, 32'h0000_0300, 32'h5555_AAAA, 1'b0, 0, 32'h0);
    push_stim(32'hE5910004, 32'h0000_0400, 32'h0, 1'b1, 0, 32'h0102_0304);
    push_stim(32'hE5910008, 32'h0000_0404, 32'h0, 1'b1, 0, 32'h0506_0708);
    push_stim(32'hE0810002, 32'h0, 32'h0, 1'b1, 0, 32'h0);
    push_stim(32'hE5810000, 32'h0000_0500, 32'hCAFE_F00D, 1'b1, 1, 32'h0);
    drain("directed");

    push_random(150);
    drain("random1");
    check32("stall_cycles_mid", stall_cycles, exp_count());

    // Reset in the middle of a long ACCESS
    push_stim(32'hE5910000, 32'h0000_0600, 32'h0, 1'b1, 40, 32'h1111_2222);
    n = 0;
    while (mem_req !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check32("reset_test_req_seen", {31'h0, mem_req}, 32'h1);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check32("arst_mem_req", {31'h0, mem_req}, 32'h0);
    check32("arst_stall_out", {31'h0, stall_out}, 32'h0);
    check32("arst_instr_output", instr_output, NOP);
    check32("arst_load_valid", {31'h0, load_valid_out}, 32'h0);
    check32("arst_stall_cycles", stall_cycles, 32'h0);
    stim_q.delete();
    exp_q.delete();
    req_q.delete();
    exp_stall    = 0;
    instr_in     = NOP;
    cond_pass_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check32("arst_hold_load_valid", {31'h0, load_valid_out}, 32'h0);
    rst_n = 1'b1;
    begin
      exp_t e;
      e.instr = NOP; e.bubble = 1'b0; e.lv = 1'b0; e.ld = '0;
      exp_q.push_back(e);
    end

    for (int unsigned i = 0; i < 4; i++) begin
      push_stim(32'hE0810000 | i, 32'h0, 32'h0, 1'b1, 0, 32'h0);
    end
    push_random(60);
    drain("random2");
    check32("stall_cycles_end", stall_cycles, exp_count());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/memory_access_pipeline_unit.md
# memory_access_pipeline_unit

Memory-access stage register of the pipeline, directly upstream of the memory-wait stage. It latches the instruction, effective address and store data from the execute stage and issues single-data-transfer requests (LDR/STR/LDRB/STRB) to data memory over a req/ready handshake. While a request is outstanding it stalls the execute stage and sends NOP bubbles downstream, then forwards the completed instruction together with its formatted load data.

## Interface
- No parameters.
- clk  in  1  stage clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_in  in  32  instruction from execute stage.
- addr_in  in  32  effective byte address computed by execute.
- str_data_in  in  32  store source register value.
- cond_pass_in  in  1  instruction condition satisfied; 0 turns a load/store into a no-op.
- mem_ready  in  1  data memory completes the current request this cycle.
- mem_rdata  in  32  read word, valid when mem_ready=1.
- mem_req  out  1  request valid.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata  out  32  write data.
- mem_byte_en  out  4  byte lane enables.
- stall_out  out  1  hold execute stage; instr_in/addr_in/str_data_in must remain stable.
- instr_output  out  32  instruction to memory-wait stage.
- load_data_out  out  32  formatted load result.
- load_valid_out  out  1  load_data_out valid this cycle.
- stall_cycles  out  32  ACCESS-cycle count (see Configuration).

## Operation
- Memory op: instr[27:26]==2'b01 and cond_pass_in=1. L = instr[20] (1 = load). B = instr[22] (1 = byte).
- Registers: instr_reg, addr_reg, wdata_reg, load_data_reg, state.
- FSM states are IDLE, ACCESS and DONE.
- IDLE and DONE: at each rising edge, latch instr_in/addr_in/str_data_in.
  - Next state is ACCESS if the latched instruction is a memory op.
  - Next state is IDLE otherwise.
- ACCESS:
  - mem_req=1, stall_out=1, instr_output=NOP. No registers latch from upstream.
  - On an edge with mem_ready=1: capture the formatted mem_rdata into load_data_reg (loads only) and go to DONE.
  - With mem_ready=0 the state holds indefinitely.
- DONE: instr_output=instr_reg; load_valid_out=L.
- IDLE: instr_output=instr_reg; load_valid_out=0.
- Outputs other than mem_req are don't-care-valid but are driven from registers in every state.
  - mem_we=L inverted.
  - mem_addr comes from addr_reg.
- Byte store: mem_byte_en = 4'b0001 << addr_reg[1:0]; mem_wdata = {4{wdata_reg[7:0]}}.
- Word store: mem_byte_en = 4'b1111; mem_wdata = wdata_reg.
- Byte load: zero-extended mem_rdata byte at lane addr_reg[1:0].
- Word load: mem_rdata rotated right by 8*addr_reg[1:0] (ARM unaligned-rotate behaviour).
- Condition-failed load/store: treated as non-memory op. It passes through without a request.
- NOP = 32'hE320F000.

## Timing
- Reset (async, immediate):
  - state=IDLE, instr_reg=NOP, addr_reg/wdata_reg/load_data_reg=0.
  - mem_req=0, stall_out=0, load_valid_out=0, instr_output=NOP, stall_cycles=0.
- Non-memory instruction: appears on instr_output 1 cycle after it is presented.
- Memory op with mem_ready=1 on the first ACCESS cycle: the sequence is 1 cycle ACCESS (NOP out), then DONE. The instruction appears 2 cycles after it is presented.
- Each additional cycle with mem_ready=0 adds one cycle of stall and one NOP.
- stall_out and mem_req are Moore outputs: high exactly in ACCESS, deasserted in DONE.
- The upstream next instruction is captured at the DONE→next edge.
- Back-to-back memory ops give DONE→ACCESS directly, with no IDLE cycle between them.
- mem_ready while not in ACCESS: ignored.
- mem_rdata is sampled only on the ready edge.
- Reset asserted during ACCESS:
  - mem_req drops immediately.
  - The pending request is abandoned.
  - No load data is delivered.

## Configuration
- MEM_STALL_COUNT_EN defined:
  - stall_cycles increments on every rising edge where state==ACCESS.
  - It saturates at 32'hFFFFFFFF and clears only on reset.
- Not defined: stall_cycles is tied to 32'h0 and no counter register exists.

## Test plan
- Reset: rst_n=0 mid-ACCESS → mem_req=0, stall_out=0 and instr_output=32'hE320F000 immediately. After release, ADD instructions flow with 1-cycle latency.
- LDR word with addr_in=32'h100, mem_ready=1 on the first ACCESS cycle, mem_rdata=32'hDEADBEEF:
  - mem_addr=32'h100, mem_byte_en=4'hF, stall_out high 1 cycle.
  - Then instr_output=LDR, load_valid_out=1, load_data_out=32'hDEADBEEF.
- LDRB addr_in=32'h103 with mem_rdata=32'hAABBCCDD → load_data_out=32'h000000AA. Unaligned LDR addr_in=32'h101 with the same data → 32'hDDAABBCC.
- STRB addr_in=32'h202, str_data_in=32'h12345678, mem_ready after 3 cycles:
  - mem_we=1, mem_byte_en=4'b0100, mem_wdata=32'h78787878.
  - stall_out held 3 cycles, 3 NOPs out.
  - load_valid_out stays 0.
- Condition-failed STR (cond_pass_in=0) → no mem_req, passes through in 1 cycle. Back-to-back LDR,LDR with immediate ready → DONE→ACCESS, with each LDR output 2 cycles apart.
- With MEM_STALL_COUNT_EN: the STRB scenario gives stall_cycles=3. Without the macro, stall_cycles stays 0.
